puf_response_buffer: RTL and testbench

//  Sits downstream of the PUF sequencer and comparator. Collects one response bit per
//  sr_en strobe into a RESP_BITS-wide shift register. On the sequencer's done pulse it

---
 rtl/puf_response_buffer.sv | 96 +++++++++
 tb/tb_puf_response_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/puf_response_buffer.sv
// puf_response_buffer: collects PUF comparator bits into a shift register and streams them out as bytes
module puf_response_buffer #(
    parameter int RESP_BITS = 256,
    parameter int BYTE_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sr_en,
    input  logic              cmp_bit,
    input  logic              done,
    input  logic              resp_ready,
    output logic              resp_valid,
    output logic [BYTE_W-1:0] resp_data,
    output logic              resp_last,
    output logic              busy,
    output logic              err
);
    localparam int NBYTES = RESP_BITS / BYTE_W;
    localparam int CW     = $clog2(RESP_BITS) + 1;
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t               state, state_nxt;
    logic [RESP_BITS-1:0] sr;
    logic [CW-1:0]        bit_cnt, cnt_fin;
    logic [IW-1:0]        byte_idx, ld_idx;
    logic [BYTE_W-1:0]    bytes [NBYTES];
    logic                 full, cap, xfer, fin, launch, load, err_nxt;

    for (genvar i = 0; i < NBYTES; i++) begin : g_byte
        assign bytes[i] = sr[RESP_BITS-1-BYTE_W*i -: BYTE_W];
    end

    assign full    = bit_cnt == CW'(RESP_BITS);
    assign cap     = state == COLLECT && sr_en && !full;
    assign launch  = state == IDLE && start;
    assign xfer    = resp_valid && resp_ready;
    assign fin     = xfer && resp_last;
    assign cnt_fin = bit_cnt + CW'(cap);
    // byte_idx names the byte on the output; the register is loaded one byte ahead on a transfer
    assign ld_idx  = byte_idx + IW'(resp_valid);
    assign load    = state == DRAIN && (!resp_valid || (xfer && !resp_last));
    assign err_nxt = launch ? 1'b0
                   : err | (sr_en && (state != COLLECT || full))
                         | (state == COLLECT && done && cnt_fin != CW'(RESP_BITS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE    ? (start ? COLLECT : IDLE)
                  : state == COLLECT ? (done ? DRAIN : COLLECT)
                  : state == DRAIN   ? (fin ? IDLE : DRAIN)
                  : IDLE;
    end

    always_comb begin
        busy = state != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr         <= '0;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            err        <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_last  <= 1'b0;
        end else begin
            err <= err_nxt;
            if (launch) begin
                sr      <= '0;
                bit_cnt <= '0;
            end else if (cap) begin
                sr      <= {sr[RESP_BITS-2:0], cmp_bit};
                bit_cnt <= bit_cnt + CW'(1);
            end
            if (state == COLLECT && done) byte_idx <= '0;
            else if (xfer && !resp_last)  byte_idx <= byte_idx + IW'(1);
            if (load) begin
                resp_valid <= 1'b1;
                resp_data  <= bytes[ld_idx];
                resp_last  <= ld_idx == IW'(NBYTES - 1);
            end else if (fin) begin
                resp_valid <= 1'b0;
                resp_data  <= '0;
                resp_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_puf_response_buffer.sv
// tb_puf_response_buffer: randomized stimulus against a queue-based behavioural model of the response buffer
module tb_puf_response_buffer;
    localparam int RB = 256;
    localparam int NB = 32;

    logic       clk = 0, rst_n = 0, start = 0, sr_en = 0, cmp_bit = 0, done = 0, resp_ready = 0;
    logic       resp_valid, resp_last, busy, err;
    logic [7:0] resp_data;

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    puf_response_buffer #(.RESP_BITS(RB), .BYTE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sr_en(sr_en), .cmp_bit(cmp_bit),
        .done(done), .resp_ready(resp_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_last(resp_last), .busy(busy), .err(err)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: mode 0 idle, 1 collecting, 2 draining; bits kept as a plain queue
    int         m_mode = 0, m_idx = 0;
    bit         m_err = 0, m_valid = 0;
    bit         cap_q[$];
    logic [7:0] m_bytes [NB];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_idx = 0; m_err = 0; m_valid = 0; cap_q.delete();
        end else if (m_mode == 0) begin
            if (start) begin m_mode = 1; cap_q.delete(); m_err = 0; end
            else if (sr_en) m_err = 1;
        end else if (m_mode == 1) begin
            if (sr_en) begin
                if (cap_q.size() < RB) cap_q.push_back(cmp_bit);
                else m_err = 1;
            end
            if (done) begin
                int pad;
                if (cap_q.size() != RB) m_err = 1;
                pad = RB - cap_q.size();
                for (int p = 0; p < RB; p++)
                    m_bytes[p/8][7-(p%8)] = (p < pad) ? 1'b0 : cap_q[p-pad];
                m_mode = 2; m_idx = 0;
            end
        end else begin
            if (sr_en) m_err = 1;
            if (!m_valid) m_valid = 1;
            else if (resp_ready) begin
                if (m_idx == NB-1) begin m_valid = 0; m_mode = 0; end
                else m_idx++;
            end
        end
    end

    always @(negedge clk) begin
        chk("valid", resp_valid, m_valid);
        chk("busy", busy, m_mode != 0);
        chk("err", err, m_err);
        chk("last", resp_last, m_valid && m_idx == NB-1);
        if (m_valid) chk("data", resp_data, m_bytes[m_idx]);
    end

    logic [7:0] got[$];
    int         xfers = 0;
    bit         last_seen = 0;

    always @(posedge clk) begin
        if (resp_valid && resp_ready) begin
            got.push_back(resp_data);
            xfers++;
            if (resp_last) last_seen = 1;
        end
    end

    bit         pat[$];
    logic [7:0] ref1[$];
    int         cyc;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fill(input int kind);
        pat.delete();
        for (int i = 0; i <= RB; i++)
            pat.push_back(kind == 0 ? (i < 8) : kind == 1 ? 1'($urandom_range(1)) : 1'((8'hA5 >> (7 - i % 8)) & 1));
    endtask

    function automatic logic [7:0] pbyte(input int k);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[7-j] = pat[8*k+j];
        return b;
    endfunction

    task automatic collect(input int n, input bit extra, input bit gaps, input bit keep_start);
        start = 1;
        tick();
        chk("err_cleared_on_start", err, 0);
        start = keep_start;
        for (int i = 0; i < n; i++) begin
            while (gaps && $urandom_range(3) == 0) begin sr_en = 0; tick(); end
            sr_en = 1; cmp_bit = pat[i];
            tick();
        end
        sr_en = extra; cmp_bit = extra ? pat[n] : 1'b0; done = 1;
        tick();
        done = 0; sr_en = 0;
    endtask

    task automatic drain(input int mode, input int stop_at, output int cycles);
        got.delete(); xfers = 0; last_seen = 0; cycles = 0;
        for (int c = 0; c < 2000 && !last_seen && !(stop_at > 0 && xfers >= stop_at); c++) begin
            resp_ready = (mode == 0) ? 1'b1
                       : (mode == 1) ? ((c % 2 == 0) && ($urandom_range(3) != 0))
                       : 1'($urandom_range(1));
            tick();
            cycles++;
        end
        if (stop_at == 0 && !last_seen) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d transfers expected %0d", xfers, NB);
        end
        resp_ready = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_valid", resp_valid, 0); chk("rst_busy", busy, 0); chk("rst_err", err, 0);
        chk("rst_last", resp_last, 0); chk("rst_data", resp_data, 0);
        rst_n = 1;
        tick();
        // test 1: FF then 31 zero bytes at full rate
        fill(0);
        collect(256, 0, 0, 0);
        drain(0, 0, cyc);
        chk("t1_xfers", 8'(xfers), 32); chk("t1_cycles", 8'(cyc), 33);
        chk("t1_b0", got[0], 8'hFF); chk("t1_b1", got[1], 8'h00); chk("t1_b31", got[31], 8'h00);
        chk("t1_err", err, 0); chk("t1_busy", busy, 0);
        ref1 = got;
        // test 2: same data with a toggling, randomly stalled consumer
        collect(256, 0, 1, 0);
        drain(1, 0, cyc);
        chk("t2_xfers", 8'(xfers), 32);
        for (int k = 0; k < NB; k++) chk("t2_byte", got[k], ref1[k]);
        // test 3: one bit short
        collect(255, 0, 0, 0);
        drain(0, 0, cyc);
        chk("t3_err", err, 1); chk("t3_b0", got[0], 8'h7F); chk("t3_b1", got[1], 8'h80);
        // test 4: 257th strobe together with done
        fill(1);
        collect(256, 1, 0, 0);
        drain(0, 0, cyc);
        chk("t4_err", err, 1); chk("t4_b0", got[0], pbyte(0)); chk("t4_b31", got[31], pbyte(31));
        // test 5: async reset during drain, then a clean A5 run
        collect(256, 0, 0, 0);
        drain(0, 10, cyc);
        chk("t5_xfers", 8'(xfers), 10);
        #1 rst_n = 0;
        #1 chk("t5_async_valid", resp_valid, 0); chk("t5_async_busy", busy, 0);
        tick(); tick();
        rst_n = 1;
        tick();
        fill(2);
        collect(256, 0, 0, 0);
        drain(0, 0, cyc);
        chk("t5_xfers_a5", 8'(xfers), 32);
        for (int k = 0; k < NB; k++) chk("t5_a5", got[k], 8'hA5);
        chk("t5_err", err, 0);
        // random run: random length, gaps and consumer
        begin
            int n = $urandom_range(250, 256);
            fill(1);
            collect(n, 0, 1, 0);
            drain(2, 0, cyc);
            chk("rand_err", err, n != 256);
        end
        // test 6: stray strobe in idle, then start held through the end of drain
        sr_en = 1;
        tick();
        sr_en = 0;
        chk("t6_idle_err", err, 1); chk("t6_idle_busy", busy, 0);
        tick();
        chk("t6_still_idle", busy, 0);
        fill(0);
        collect(256, 0, 0, 1);
        sr_en = 1;
        tick();
        sr_en = 0;
        drain(0, 0, cyc);
        chk("t6_end_busy", busy, 0); chk("t6_end_err", err, 1);
        tick();
        chk("t6_recollect_busy", busy, 1); chk("t6_recollect_err", err, 0);
        start = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
